// File: rtl/dcache_ctl_if.sv
// Core request, tag RAM and memory burst signals of the data-cache controller.
interface dcache_ctl_if #(
    parameter int unsigned LSS = 8,
    parameter int unsigned TS  = 21
);
    logic            req_valid;
    logic [31:0]     req_addr;
    logic            req_write;
    logic            req_ready;
    logic            resp_valid;
    logic            resp_hit;
    logic [LSS-1:0]  tag_read_sel;
    logic [TS-1:0]   tag_read_port;
    logic [LSS-1:0]  tag_write_sel;
    logic [TS-1:0]   tag_write_port;
    logic            tag_wr_ena;
    logic            mem_req;
    logic            mem_wr;
    logic [31:0]     mem_addr;
    logic            mem_ack;
    logic [2:0]      beat;
    logic            fill_we;
    logic            wb_re;

    // Controller side
    modport slave (
        input  req_valid, req_addr, req_write, tag_read_port, mem_ack,
        output req_ready, resp_valid, resp_hit, tag_read_sel, tag_write_sel,
               tag_write_port, tag_wr_ena, mem_req, mem_wr, mem_addr, beat,
               fill_we, wb_re
    );

    // Core / tag RAM / bus side
    modport master (
        output req_valid, req_addr, req_write, tag_read_port, mem_ack,
        input  req_ready, resp_valid, resp_hit, tag_read_sel, tag_write_sel,
               tag_write_port, tag_wr_ena, mem_req, mem_wr, mem_addr, beat,
               fill_we, wb_re
    );
endinterface

// File: rtl/dcache_ctl.sv
// Direct-mapped data-cache controller: tag lookup, dirty writeback, line fill, tag update.
module dcache_ctl (
    input  logic        nGCLK,
    input  logic        reset,
    dcache_ctl_if.slave bus
);
    localparam int unsigned NL  = 256;
    localparam int unsigned LSS = 8;
    localparam int unsigned LSH = LSS + 4;
    localparam int unsigned PSL = LSH + 1;
    localparam int unsigned TS  = 2 + (32 - PSL);
    localparam int unsigned TGW = 32 - PSL;
    localparam int unsigned BW  = 3;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, UPDATE} state_t;

    state_t          state, state_nxt;
    logic [31:5]     req_blk_q;
    logic            req_write_q;
    logic [TGW-1:0]  victim_tag_q;
    logic [BW-1:0]   beat_q;

    logic [TGW-1:0]  req_tag;
    logic [LSS-1:0]  req_line;
    logic [TGW-1:0]  rd_tag;
    logic            rd_v;
    logic            rd_d;
    logic            hit;
    logic            last_beat;

    assign req_tag   = req_blk_q[31:PSL];
    assign req_line  = req_blk_q[LSH:5];
    assign rd_v      = bus.tag_read_port[TS-1];
    assign rd_d      = bus.tag_read_port[TS-2];
    assign rd_tag    = bus.tag_read_port[TS-3:0];
    assign hit       = rd_v && (rd_tag == req_tag);
    assign last_beat = bus.mem_ack && (beat_q == BW'(NL'(7)));
    assign bus.beat  = beat_q;

    // State register
    always_ff @(posedge nGCLK) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Request latch, victim tag capture and burst beat counter
    always_ff @(posedge nGCLK) begin
        if (reset) begin
            req_blk_q    <= '0;
            req_write_q  <= 1'b0;
            victim_tag_q <= '0;
            beat_q       <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                req_blk_q   <= bus.req_addr[31:5];
                req_write_q <= bus.req_write;
            end
            if (state == LOOKUP) victim_tag_q <= rd_tag;
            if (state == WB || state == FILL) begin
                if (bus.mem_ack) beat_q <= beat_q + BW'(1);
            end else begin
                beat_q <= '0;
            end
        end
    end

    // Next state and tag/bus/response outputs
    always_comb begin
        state_nxt          = state;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_hit       = 1'b0;
        bus.tag_read_sel   = req_line;
        bus.tag_write_sel  = '0;
        bus.tag_write_port = '0;
        bus.tag_wr_ena     = 1'b0;
        bus.mem_req        = 1'b0;
        bus.mem_wr         = 1'b0;
        bus.mem_addr       = '0;
        bus.fill_we        = 1'b0;
        bus.wb_re          = 1'b0;
        unique case (state)
            IDLE: begin
                bus.req_ready    = 1'b1;
                bus.tag_read_sel = bus.req_addr[LSH:5];
                if (bus.req_valid) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_hit   = 1'b1;
                    // First store to a clean line marks it dirty
                    if (req_write_q && !rd_d) begin
                        bus.tag_wr_ena     = 1'b1;
                        bus.tag_write_sel  = req_line;
                        bus.tag_write_port = {1'b1, 1'b1, req_tag};
                    end
                    state_nxt = IDLE;
                end else if (rd_v && rd_d) begin
                    state_nxt = WB;
                end else begin
                    state_nxt = FILL;
                end
            end
            WB: begin
                bus.mem_req  = 1'b1;
                bus.mem_wr   = 1'b1;
                bus.mem_addr = {victim_tag_q, req_line, 5'b0};
                bus.wb_re    = 1'b1;
                if (last_beat) state_nxt = FILL;
            end
            FILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {req_tag, req_line, 5'b0};
                bus.fill_we  = bus.mem_ack;
                if (last_beat) state_nxt = UPDATE;
            end
            UPDATE: begin
                bus.tag_wr_ena     = 1'b1;
                bus.tag_write_sel  = req_line;
                bus.tag_write_port = {1'b1, req_write_q, req_tag};
                bus.resp_valid     = 1'b1;
                state_nxt          = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_ctl.sv
// Bench for dcache_ctl: tag RAM and bus models, directed table, reset sequence, random traffic.
module tb_dcache_ctl;
    localparam int unsigned LSS = 8;
    localparam int unsigned LSH = LSS + 4;
    localparam int unsigned PSL = LSH + 1;
    localparam int unsigned TS  = 2 + (32 - PSL);
    localparam int unsigned TGW = 32 - PSL;

    logic nGCLK = 1'b0;
    logic reset;
    dcache_ctl_if bus ();

    dcache_ctl dut (.nGCLK(nGCLK), .reset(reset), .bus(bus));

    always #5 nGCLK = ~nGCLK;

    // Tag RAM: registered read with write-through forwarding
    logic [TS-1:0] tram [256];
    always @(posedge nGCLK) begin
        if (bus.tag_wr_ena) tram[bus.tag_write_sel] <= bus.tag_write_port;
        bus.tag_read_port <= (bus.tag_wr_ena && bus.tag_write_sel == bus.tag_read_sel)
                             ? bus.tag_write_port : tram[bus.tag_read_sel];
    end

    // Reference cache contents
    bit             m_v   [256];
    bit             m_d   [256];
    logic [TGW-1:0] m_tag [256];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One request; phases tracked by counting acked beats
    task automatic do_req(input logic [31:0] addr, input bit wr, input int thr, input bit tog,
                          output bit got_hit, output bit got_dirty);
        logic [7:0]     line;
        logic [TGW-1:0] tg;
        bit             hit, dirty, ack, wr_set;
        logic [31:0]    wb_a, fill_a;
        logic [10:0]    ev, av;
        int             phase, acks, fills;
        line   = addr[LSH:5];
        tg     = addr[31:PSL];
        hit    = m_v[line] && (m_tag[line] == tg);
        dirty  = !hit && m_v[line] && m_d[line];
        wr_set = hit && wr && !m_d[line];
        wb_a   = {m_tag[line], line, 5'b0};
        fill_a = {tg, line, 5'b0};
        got_hit = 1'b0; got_dirty = 1'b0;
        phase = 0; acks = 0; fills = 0;

        @(negedge nGCLK);
        bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_write = wr; bus.mem_ack = 1'b0;
        #1;
        check("accept_ready", bus.req_ready, 1'b1);
        check("read_sel", bus.tag_read_sel, line);

        for (int cyc = 0; cyc < 400 && phase != 4; cyc++) begin
            @(negedge nGCLK);
            bus.req_valid = tog ? 1'($urandom_range(1)) : 1'b0;
            if (tog) bus.req_addr = $urandom;
            ack = (phase == 1 || phase == 2) && ($urandom_range(99) < 32'(thr));
            bus.mem_ack = ack;
            #1;
            av = {bus.req_ready, bus.resp_valid, bus.resp_hit, bus.mem_req, bus.mem_wr,
                  bus.beat, bus.wb_re, bus.fill_we, bus.tag_wr_ena};
            got_dirty = got_dirty | (bus.mem_req & bus.mem_wr);
            case (phase)
                0: ev = {1'b0, hit, hit, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, wr_set};
                1: ev = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'(acks), 1'b1, 1'b0, 1'b0};
                2: ev = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'(acks), 1'b0, ack, 1'b0};
                default: ev = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
            endcase
            check($sformatf("ctl_ph%0d", phase), av, ev);
            if (phase == 1) check("wb_addr", bus.mem_addr, wb_a);
            if (phase == 2) check("fill_addr", bus.mem_addr, fill_a);
            if (phase == 0 && wr_set)
                check("dirty_write", {bus.tag_write_sel, bus.tag_write_port}, {line, 1'b1, 1'b1, tg});
            if (phase == 3)
                check("update_write", {bus.tag_write_sel, bus.tag_write_port}, {line, 1'b1, wr, tg});
            if (bus.resp_valid) got_hit = bus.resp_hit;
            if (bus.fill_we) fills++;
            case (phase)
                0: begin
                    if (hit) begin
                        if (wr) m_d[line] = 1'b1;
                        phase = 4;
                    end else begin
                        phase = dirty ? 1 : 2;
                    end
                end
                1: begin
                    if (ack) acks++;
                    if (acks == 8) begin acks = 0; phase = 2; end
                end
                2: begin
                    if (ack) acks++;
                    if (acks == 8) phase = 3;
                end
                default: begin
                    m_v[line] = 1'b1; m_d[line] = wr; m_tag[line] = tg;
                    phase = 4;
                end
            endcase
        end
        if (phase != 4) check("req_timeout", 32'(phase), 32'd4);
        if (!hit) check("fill_count", 32'(fills), 32'd8);

        @(negedge nGCLK);
        bus.req_valid = 1'b0; bus.mem_ack = 1'b0;
        #1;
        check("idle_ready", bus.req_ready, 1'b1);
        check("tag_entry", tram[line], {m_v[line], m_d[line], m_tag[line]});
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        int          thr;
        bit          tog;
        bit          exp_hit;
        bit          exp_dirty;
    } vec_t;

    vec_t tbl [8];
    bit   gh, gd;

    initial begin
        tbl[0] = '{32'h0000_1040, 1'b0, 100, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_1040, 1'b0, 100, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{32'h0000_1044, 1'b1, 100, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{32'h0000_3040, 1'b0, 100, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{32'h0000_5080, 1'b1,  40, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{32'h0000_5080, 1'b0, 100, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{32'h0000_1040, 1'b0,  60, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{32'h0000_104c, 1'b1, 100, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 256; i++) begin
            tram[i] = '0; m_v[i] = 1'b0; m_d[i] = 1'b0; m_tag[i] = '0;
        end
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.mem_ack = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge nGCLK);
        @(negedge nGCLK);
        #1;
        check("rst_ctl", {bus.req_ready, bus.resp_valid, bus.resp_hit, bus.mem_req, bus.mem_wr,
                          bus.beat, bus.wb_re, bus.fill_we, bus.tag_wr_ena}, 11'b100_0000_0000);
        check("rst_wr_bus", {bus.mem_addr, bus.tag_write_sel, bus.tag_write_port}, '0);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_req(tbl[i].addr, tbl[i].wr, tbl[i].thr, tbl[i].tog, gh, gd);
            check($sformatf("tbl%0d_hit", i), gh, tbl[i].exp_hit);
            check($sformatf("tbl%0d_dirty", i), gd, tbl[i].exp_dirty);
        end

        // Reset during writeback beat 4 (line 0x84 holds dirty tag 2)
        @(negedge nGCLK);
        bus.req_valid = 1'b1; bus.req_addr = 32'h0000_7080; bus.req_write = 1'b0;
        @(negedge nGCLK);
        bus.req_valid = 1'b0;
        #1;
        check("rst_lookup", {bus.resp_valid, bus.mem_req}, 2'b00);
        for (int b = 0; b < 4; b++) begin
            @(negedge nGCLK);
            bus.mem_ack = 1'b1;
            #1;
            check("rst_wb_beat", {bus.mem_req, bus.mem_wr, bus.beat, bus.mem_addr},
                  {1'b1, 1'b1, 3'(b), 32'h0000_5080});
        end
        @(negedge nGCLK);
        bus.mem_ack = 1'b0;
        #1;
        check("rst_at_beat4", {bus.mem_req, bus.beat}, {1'b1, 3'd4});
        reset = 1'b1;
        @(negedge nGCLK);
        #1;
        check("rst_abort", {bus.req_ready, bus.mem_req, bus.tag_wr_ena}, 3'b100);
        reset = 1'b0;
        check("rst_tag_kept", tram[8'h84], {1'b1, 1'b1, 19'd2});
        do_req(32'h0000_5080, 1'b0, 100, 1'b0, gh, gd);
        check("rst_after_hit", {gh, gd}, 2'b10);

        // Random traffic over a few lines and tags
        for (int n = 0; n < 40; n++) begin
            logic [7:0]  ln;
            logic [31:0] a;
            case ($urandom_range(3))
                0: ln = 8'h02;
                1: ln = 8'h82;
                2: ln = 8'h84;
                default: ln = 8'h10;
            endcase
            a = {19'($urandom_range(3)), ln, 3'($urandom_range(7)), 2'b00};
            do_req(a, 1'($urandom_range(1)), $urandom_range(30, 100), 1'($urandom_range(1)), gh, gd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
